// File: rtl/stage_sequencer_pkg.sv
// Shared definitions for the stage sequencer.
//   - FSM state encoding (3-bit, legacy-compatible localparams)
//   - stage index constants for the 12-stage drawing pipeline
//   - default stage count
package stage_sequencer_pkg;

  localparam int NUM_STAGES_DEF = 12;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_RUN    = 3'd2;
  localparam logic [2:0] ST_GAP    = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;
  localparam logic [2:0] ST_ERROR  = 3'd5;

  localparam logic [3:0] STG_CLEAR     = 4'd0;
  localparam logic [3:0] STG_GET_INPUT = 4'd1;
  localparam logic [3:0] STG_PARSE     = 4'd2;
  localparam logic [3:0] STG_LAYOUT    = 4'd3;
  localparam logic [3:0] STG_EDIT      = 4'd4;
  localparam logic [3:0] STG_ROUTE     = 4'd5;
  localparam logic [3:0] STG_PLACE     = 4'd6;
  localparam logic [3:0] STG_WIRE      = 4'd7;
  localparam logic [3:0] STG_LABEL     = 4'd8;
  localparam logic [3:0] STG_CHECK     = 4'd9;
  localparam logic [3:0] STG_SCALE     = 4'd10;
  localparam logic [3:0] STG_DRAW      = 4'd11;

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage watchdog counter.
//   clk, reset : clock, synchronous active-high reset
//   clear      : zero the counter (issued when a stage is started)
//   enable     : count this cycle (stage running and not interactive)
//   expire     : counter has reached LIMIT-1 while enabled
// The counter stops at LIMIT-1 so it can never wrap back to a safe value.
module stage_watchdog #(
  parameter logic [23:0] LIMIT = 24'd16_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [23:0] count;
  logic        at_limit;

  assign at_limit = (count == LIMIT - 24'd1);
  assign expire   = enable && at_limit;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !at_limit) begin
      count <= count + 24'd1;
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// Sequencer that walks the drawing pipeline one stage at a time.
//   clk, reset         : clock, synchronous active-high reset
//   go                 : user key level; only its rising edge advances
//   stage_done         : per-stage completion flags (bit k from stage k)
//   program_initialize : idle, waiting for the first go
//   run                : one-hot (or zero) enable for the datapath mux
//   stage_start        : one-cycle start pulse to the selected stage
//   cur_stage          : active or last-run stage index
//   busy/finished/error: status flags
//   error_stage        : index of the stage whose watchdog expired
//   state_dbg          : current FSM state for observation
// Handshake: stage k is started by a one-cycle stage_start[k]; it holds
// run[k] until the sequencer samples stage_done[k] high in a RUN cycle.
// done is not looked at in the START cycle, and done bits of other stages
// are ignored. A GAP cycle with run=0 separates consecutive stages.
// All outputs are registered from the next-state values.
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int                    NUM_STAGES       = NUM_STAGES_DEF,
  parameter logic [23:0]           TIMEOUT          = 24'd16_000_000,
  parameter logic [NUM_STAGES-1:0] INTERACTIVE_MASK = NUM_STAGES'(12'b0000_0001_0010)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic                  program_initialize,
  output logic [NUM_STAGES-1:0] run,
  output logic [NUM_STAGES-1:0] stage_start,
  output logic [3:0]            cur_stage,
  output logic                  busy,
  output logic                  finished,
  output logic                  error,
  output logic [3:0]            error_stage,
  output logic [2:0]            state_dbg
);

  localparam logic [3:0] LAST_STAGE = 4'(NUM_STAGES - 1);

  logic [2:0] state, state_d;
  logic [3:0] k, k_d;
  logic       go_q;
  logic       go_edge;
  logic       wd_clear, wd_enable, wd_expire;

  assign go_edge   = go && !go_q;
  assign wd_clear  = (state == ST_START);
  assign wd_enable = (state == ST_RUN) && !INTERACTIVE_MASK[k];
  assign state_dbg = state;

  stage_watchdog #(.LIMIT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expire (wd_expire)
  );

  always_comb begin
    state_d = state;
    k_d     = k;
    unique case (state)
      ST_IDLE: begin
        if (go_edge) begin
          state_d = ST_START;
          k_d     = STG_CLEAR;
        end
      end
      ST_START: state_d = ST_RUN;
      ST_RUN: begin
        // Completion takes priority over a watchdog expiry on the same cycle.
        if (stage_done[k]) state_d = ST_GAP;
        else if (wd_expire) state_d = ST_ERROR;
      end
      ST_GAP: begin
        if (k == LAST_STAGE) begin
          state_d = ST_FINISH;
        end else begin
          state_d = ST_START;
          k_d     = k + 4'd1;
        end
      end
      ST_FINISH: begin
        if (go_edge) begin
          state_d = ST_START;
          k_d     = STG_CLEAR;
        end
      end
      ST_ERROR: begin
        if (go_edge) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= ST_IDLE;
      k                  <= '0;
      go_q               <= 1'b1;  // a key held through reset must not start a run
      program_initialize <= 1'b1;
      run                <= '0;
      stage_start        <= '0;
      cur_stage          <= '0;
      busy               <= 1'b0;
      finished           <= 1'b0;
      error              <= 1'b0;
      error_stage        <= '0;
    end else begin
      state              <= state_d;
      k                  <= k_d;
      go_q               <= go;
      program_initialize <= (state_d == ST_IDLE);
      run                <= (state_d == ST_START || state_d == ST_RUN)
                            ? (NUM_STAGES'(1) << k_d) : '0;
      stage_start        <= (state_d == ST_START) ? (NUM_STAGES'(1) << k_d) : '0;
      cur_stage          <= k_d;
      busy               <= (state_d == ST_START || state_d == ST_RUN || state_d == ST_GAP);
      finished           <= (state_d == ST_FINISH);
      error              <= (state_d == ST_ERROR);
      if (state == ST_RUN && state_d == ST_ERROR) error_stage <= k;
    end
  end

endmodule

// File: tb/tb_stage_sequencer.sv
module tb_stage_sequencer;

  localparam int          NS  = 12;
  localparam logic [23:0] TMO = 24'd100;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          go = 1'b0;
  logic [NS-1:0] stage_done = '0;
  logic          program_initialize;
  logic [NS-1:0] run;
  logic [NS-1:0] stage_start;
  logic [3:0]    cur_stage;
  logic          busy, finished, error;
  logic [3:0]    error_stage;
  logic [2:0]    state_dbg;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  stage_sequencer #(.NUM_STAGES(NS), .TIMEOUT(TMO)) dut (
    .clk                (clk),
    .reset              (reset),
    .go                 (go),
    .stage_done         (stage_done),
    .program_initialize (program_initialize),
    .run                (run),
    .stage_start        (stage_start),
    .cur_stage          (cur_stage),
    .busy               (busy),
    .finished           (finished),
    .error              (error),
    .error_stage        (error_stage),
    .state_dbg          (state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // reference model helpers, straight from the stage rules
  function automatic logic [NS-1:0] onehot(input int k);
    logic [NS-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  function automatic bit interactive(input int k);
    return (k == 1) || (k == 4);
  endfunction

  function automatic bit will_timeout(input int k, input int d);
    return !interactive(k) && (d > int'(TMO));
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, "_init"}, program_initialize, 1);
    chk({tag, "_run"}, run, 0);
    chk({tag, "_start"}, stage_start, 0);
    chk({tag, "_cur"}, cur_stage, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_fin"}, finished, 0);
    chk({tag, "_err"}, error, 0);
    chk({tag, "_errstg"}, error_stage, 0);
  endtask

  // Called in the START cycle of stage k. d = RUN cycle on which done[k]
  // is presented (1 = first RUN cycle). start_noise is driven on
  // stage_done during START. Returns 1 if the stage ended in ERROR.
  task automatic do_stage(input int k, input int d, input logic [NS-1:0] start_noise,
                          output bit errored);
    int n_run;
    logic [NS-1:0] noise;
    errored = will_timeout(k, d);
    n_run   = errored ? int'(TMO) : d;
    chk($sformatf("start_pulse_s%0d", k), stage_start, onehot(k));
    chk($sformatf("start_run_s%0d", k), run, onehot(k));
    chk($sformatf("start_busy_s%0d", k), busy, 1);
    chk($sformatf("start_cur_s%0d", k), cur_stage, k);
    chk($sformatf("start_init_s%0d", k), program_initialize, 0);
    stage_done = start_noise;
    tick();
    for (int i = 1; i <= n_run; i++) begin
      chk($sformatf("run_s%0d_c%0d", k, i), run, onehot(k));
      chk($sformatf("run_nostart_s%0d_c%0d", k, i), stage_start, 0);
      chk($sformatf("run_err_s%0d_c%0d", k, i), error, 0);
      noise = NS'($urandom);
      if (i == d) stage_done = noise | onehot(k);
      else        stage_done = noise & ~onehot(k);
      tick();
    end
    stage_done = '0;
    if (errored) begin
      chk($sformatf("tmo_err_s%0d", k), error, 1);
      chk($sformatf("tmo_errstg_s%0d", k), error_stage, k);
      chk($sformatf("tmo_run_s%0d", k), run, 0);
      chk($sformatf("tmo_busy_s%0d", k), busy, 0);
      chk($sformatf("tmo_fin_s%0d", k), finished, 0);
    end else begin
      chk($sformatf("gap_run_s%0d", k), run, 0);
      chk($sformatf("gap_start_s%0d", k), stage_start, 0);
      chk($sformatf("gap_busy_s%0d", k), busy, 1);
      chk($sformatf("gap_err_s%0d", k), error, 0);
      tick();
    end
  endtask

  task automatic load_order();
    exp_q.delete();
    for (int s = 0; s < NS; s++) exp_q.push_back(4'(s));
  endtask

  task automatic check_finish(input string tag);
    chk({tag, "_fin"}, finished, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_run"}, run, 0);
    chk({tag, "_start"}, stage_start, 0);
    chk({tag, "_cur"}, cur_stage, NS - 1);
    chk({tag, "_err"}, error, 0);
  endtask

  initial begin
    bit  err;
    int  k;
    int  d;
    // reset held for a few cycles
    reset = 1'b1;
    repeat (3) tick();
    check_reset_values("reset");
    reset = 1'b0;
    tick();
    check_reset_values("idle");

    // full walk, each done 3 cycles after its start
    go = 1'b1;
    tick();
    go = 1'b0;
    load_order();
    while (exp_q.size() > 0) begin
      k = int'(exp_q.pop_front());
      do_stage(k, 3, '0, err);
    end
    check_finish("fin1");
    repeat ($urandom_range(2, 5)) tick();
    check_finish("fin1_hold");

    // rerun from FINISH with go held high the whole time; random done
    // delays, all-ones done during stage 0 START, done/timeout collision
    // on stage 2, interactive stage 4 held for 1000 cycles
    go = 1'b1;
    tick();
    load_order();
    while (exp_q.size() > 0) begin
      k = int'(exp_q.pop_front());
      d = $urandom_range(1, 8);
      if (k == 2) d = int'(TMO);
      if (k == 4) d = 1000;
      do_stage(k, d, (k == 0) ? '1 : NS'($urandom) & ~onehot(k), err);
      chk($sformatf("rerun_noerr_s%0d", k), err, 0);
    end
    check_finish("fin2");
    repeat (5) tick();
    check_finish("fin2_go_held");

    // timeout on stage 2
    go = 1'b0;
    tick();
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int s = 0; s < 2; s++) do_stage(s, $urandom_range(1, 6), '0, err);
    do_stage(2, int'(TMO) + 50, '0, err);
    repeat (3) tick();
    chk("err_hold", error, 1);
    chk("err_hold_run", run, 0);
    go = 1'b1;
    tick();
    chk("err_go_init", program_initialize, 1);
    chk("err_go_err", error, 0);
    chk("err_go_run", run, 0);
    chk("err_go_busy", busy, 0);
    go = 1'b0;
    tick();
    chk("err_idle_nostart", stage_start, 0);

    // reset in the middle of stage 6 with go held through reset
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int s = 0; s < 6; s++) do_stage(s, $urandom_range(1, 6), '0, err);
    chk("s6_start", stage_start, onehot(6));
    tick();
    repeat ($urandom_range(1, 5)) begin
      chk("s6_run", run, onehot(6));
      tick();
    end
    go = 1'b1;
    reset = 1'b1;
    tick();
    check_reset_values("midrst");
    reset = 1'b0;
    repeat (5) begin
      tick();
      check_reset_values("rst_go_held");
    end
    go = 1'b0;
    tick();
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("post_rst_start", stage_start, onehot(0));
    chk("post_rst_run", run, onehot(0));
    chk("post_rst_busy", busy, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
